// File: rtl/mod_segment_streamer_pkg.sv
// Shared modulation-pipe definitions: segment-streamer defaults, symbol-count
// width and buffer-occupancy state encoding.
package mod_segment_streamer_pkg;

    localparam int unsigned SEG_NUM_DEF  = 8;
    localparam int unsigned SEG_DATA_W_DEF = 32;
    localparam int unsigned SYMCNT_W     = 16;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/mod_segment_streamer_seg_sym_buffer.sv
// One symbol buffer: NUM_SEG x DATA_W words, written as a whole symbol,
// read one segment at a time by index.
module seg_sym_buffer
    import mod_segment_streamer_pkg::*;
#(
    parameter int unsigned NUM_SEG = SEG_NUM_DEF,
    parameter int unsigned DATA_W  = SEG_DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wr_en,
    input  logic [NUM_SEG*DATA_W-1:0]   i_wr_data,
    input  logic [$clog2(NUM_SEG)-1:0]  i_rd_idx,
    output logic [DATA_W-1:0]           o_rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_SEG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_wr_en) begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                r_mem[k] <= i_wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/mod_segment_streamer.sv
// Ping-pong segment streamer: captures whole symbols, emits one segment word
// per cycle over valid/ready. Optional symbol counter: SEG_STREAM_SYMCNT_EN.
module mod_segment_streamer
    import mod_segment_streamer_pkg::*;
#(
    parameter int unsigned NUM_SEG = SEG_NUM_DEF,
    parameter int unsigned DATA_W  = SEG_DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SEG*DATA_W-1:0]   seg_in,
    input  logic                        seg_valid,
    output logic                        seg_ready,
    output logic [DATA_W-1:0]           sample_out,
    output logic                        sample_valid,
    input  logic                        sample_ready,
`ifdef SEG_STREAM_SYMCNT_EN
    output logic                        sample_last,
    output logic [SYMCNT_W-1:0]         symbol_count
`else
    output logic                        sample_last
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_SEG);

    cnt_state_e         r_state;
    cnt_state_e         w_state_nxt;
    logic               r_wr_sel;
    logic               r_rd_sel;
    logic [IDX_W-1:0]   r_seg_idx;

    logic               w_accept;
    logic               w_emit;
    logic               w_seg_last;
    logic               w_complete;
    logic [DATA_W-1:0]  w_rd_data0;
    logic [DATA_W-1:0]  w_rd_data1;

    // Readiness comes from registered occupancy only, never from seg_valid/sample_ready.
    assign w_accept   = seg_valid && (r_state != CNT_FULL);
    assign w_emit     = (r_state != CNT_EMPTY) && sample_ready;
    assign w_seg_last = (r_seg_idx == IDX_W'(NUM_SEG - 1));
    assign w_complete = w_emit && w_seg_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CNT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        seg_ready    = 1'b1;
        sample_valid = 1'b0;
        case (r_state)
            CNT_EMPTY: begin
                if (w_accept) w_state_nxt = CNT_ONE;
            end
            CNT_ONE: begin
                sample_valid = 1'b1;
                if (w_accept && !w_complete)      w_state_nxt = CNT_FULL;
                else if (!w_accept && w_complete) w_state_nxt = CNT_EMPTY;
            end
            CNT_FULL: begin
                seg_ready    = 1'b0;
                sample_valid = 1'b1;
                if (w_complete) w_state_nxt = CNT_ONE;
            end
            default: begin
                w_state_nxt = CNT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_seg_idx <= '0;
        end else begin
            if (w_accept) r_wr_sel <= ~r_wr_sel;
            if (w_emit) begin
                if (w_seg_last) begin
                    r_seg_idx <= '0;
                    r_rd_sel  <= ~r_rd_sel;
                end else begin
                    r_seg_idx <= r_seg_idx + IDX_W'(1);
                end
            end
        end
    end

    seg_sym_buffer #(
        .NUM_SEG (NUM_SEG),
        .DATA_W  (DATA_W)
    ) u_buf0 (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_accept && !r_wr_sel),
        .i_wr_data (seg_in),
        .i_rd_idx  (r_seg_idx),
        .o_rd_data (w_rd_data0)
    );

    seg_sym_buffer #(
        .NUM_SEG (NUM_SEG),
        .DATA_W  (DATA_W)
    ) u_buf1 (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_accept && r_wr_sel),
        .i_wr_data (seg_in),
        .i_rd_idx  (r_seg_idx),
        .o_rd_data (w_rd_data1)
    );

    assign sample_out  = r_rd_sel ? w_rd_data1 : w_rd_data0;
    assign sample_last = sample_valid && w_seg_last;

`ifdef SEG_STREAM_SYMCNT_EN
    logic [SYMCNT_W-1:0] r_symbol_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_symbol_count <= '0;
        end else if (w_complete) begin
            r_symbol_count <= r_symbol_count + SYMCNT_W'(1);
        end
    end

    assign symbol_count = r_symbol_count;
`endif

endmodule

// File: tb/tb_mod_segment_streamer.sv
// Directed self-checking bench for mod_segment_streamer (NUM_SEG=8, DATA_W=32).
// Symbol-counter checks are compiled only with SEG_STREAM_SYMCNT_EN.
module tb_mod_segment_streamer;

    localparam int unsigned NUM_SEG = 8;
    localparam int unsigned DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_SEG*DATA_W-1:0] seg_in;
    logic                      seg_valid;
    logic                      seg_ready;
    logic [DATA_W-1:0]         sample_out;
    logic                      sample_valid;
    logic                      sample_ready;
    logic                      sample_last;
`ifdef SEG_STREAM_SYMCNT_EN
    logic [15:0]               symbol_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    mod_segment_streamer #(
        .NUM_SEG (NUM_SEG),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .seg_valid    (seg_valid),
        .seg_ready    (seg_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
`ifdef SEG_STREAM_SYMCNT_EN
        .sample_last  (sample_last),
        .symbol_count (symbol_count)
`else
        .sample_last  (sample_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_SEG*DATA_W-1:0] mk_sym(input logic [31:0] base);
        logic [NUM_SEG*DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_SEG; k++) v[k*DATA_W +: DATA_W] = base + 32'(k);
        return v;
    endfunction

    task automatic check_idle(input string name);
        tests_run++;
        if (seg_ready !== 1'b1 || sample_valid !== 1'b0 || sample_out !== 32'h0 || sample_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: ready=%b valid=%b out=%h last=%b, required ready=1 valid=0 out=0 last=0",
                     name, seg_ready, sample_valid, sample_out, sample_last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; seg_valid = 1'b0; sample_ready = 1'b0; seg_in = '0;
        repeat (3) tick();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle("reset_idle");
        end
`ifdef SEG_STREAM_SYMCNT_EN
        tests_run++;
        if (symbol_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_symcnt: got %h required 0000", symbol_count);
        end
`endif
    endtask

    task automatic test_single();
        seg_in = mk_sym(32'h0); seg_valid = 1'b1; sample_ready = 1'b1;
        tick();
        seg_valid = 1'b0;
        for (int k = 0; k < NUM_SEG; k++) begin
            tests_run++;
            if (sample_valid !== 1'b1 || sample_out !== 32'(k) || sample_last !== (k == NUM_SEG - 1)) begin
                tests_failed++;
                $display("FAIL single_seg%0d: valid=%b out=%h last=%b, required valid=1 out=%h last=%b",
                         k, sample_valid, sample_out, sample_last, 32'(k), (k == NUM_SEG - 1));
            end
            tick();
        end
        tests_run++;
        if (sample_valid !== 1'b0 || seg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_drained: valid=%b ready=%b, required valid=0 ready=1", sample_valid, seg_ready);
        end
`ifdef SEG_STREAM_SYMCNT_EN
        tests_run++;
        if (symbol_count !== 16'h1) begin
            tests_failed++;
            $display("FAIL single_symcnt: got %h required 0001", symbol_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        logic [31:0] exp_out;
        sample_ready = 1'b0;
        seg_in = mk_sym(32'h100); seg_valid = 1'b1;
        tick();
        seg_in = mk_sym(32'h200);
        tests_run++;
        if (seg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_one: got %b required 1", seg_ready);
        end
        tick();
        seg_in = mk_sym(32'h300);
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (seg_ready !== 1'b0 || sample_out !== 32'h100 || sample_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_full_hold: ready=%b valid=%b out=%h, required ready=0 valid=1 out=00000100",
                         seg_ready, sample_valid, sample_out);
            end
            tick();
        end
        sample_ready = 1'b1;
        // C is offered throughout; it may only enter once A has completed.
        for (int i = 0; i < 3 * NUM_SEG; i++) begin
            exp_rdy = (i == 8) || (i >= 16);
            exp_out = 32'h100 * (i / 8 + 1) + 32'(i % 8);
            tests_run++;
            if (sample_valid !== 1'b1 || sample_out !== exp_out || sample_last !== ((i % 8) == 7)
                || seg_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL b2b_stream%0d: valid=%b out=%h last=%b ready=%b, required valid=1 out=%h last=%b ready=%b",
                         i, sample_valid, sample_out, sample_last, seg_ready, exp_out, ((i % 8) == 7), exp_rdy);
            end
            if (seg_valid && seg_ready) begin
                tick();
                seg_valid = 1'b0;
            end else begin
                tick();
            end
        end
        tests_run++;
        if (sample_valid !== 1'b0 || seg_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drained: valid=%b seg_valid_pending=%b, required 0 0", sample_valid, seg_valid);
            seg_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        int idx;
        idx = 0;
        sample_ready = 1'b0;
        seg_in = mk_sym(32'h400); seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
        for (int c = 0; c < 40 && idx < NUM_SEG; c++) begin
            sample_ready = c[0];
            tests_run++;
            if (sample_valid !== 1'b1 || sample_out !== 32'h400 + 32'(idx) || sample_last !== (idx == NUM_SEG - 1)) begin
                tests_failed++;
                $display("FAIL stall_c%0d: valid=%b out=%h last=%b, required valid=1 out=%h last=%b",
                         c, sample_valid, sample_out, sample_last, 32'h400 + 32'(idx), (idx == NUM_SEG - 1));
            end
            if (sample_ready) idx++;
            tick();
        end
        sample_ready = 1'b0;
        tests_run++;
        if (idx != NUM_SEG || sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_done: consumed=%0d valid=%b, required consumed=8 valid=0", idx, sample_valid);
        end
    endtask

    task automatic test_reset_mid();
        sample_ready = 1'b1;
        seg_in = mk_sym(32'h500); seg_valid = 1'b1;
        tick();
        seg_in = mk_sym(32'h600);
        tick();
        seg_valid = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (sample_out !== 32'h504 || seg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_pre: out=%h ready=%b, required out=00000504 ready=0", sample_out, seg_ready);
        end
        reset = 1'b0;
        #2;
        check_idle("rstmid_async");
        tick();
        reset = 1'b1;
        tick();
        check_idle("rstmid_released");
`ifdef SEG_STREAM_SYMCNT_EN
        tests_run++;
        if (symbol_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL rstmid_symcnt: got %h required 0000", symbol_count);
        end
`endif
        seg_in = mk_sym(32'h700); seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
        for (int k = 0; k < NUM_SEG; k++) begin
            tests_run++;
            if (sample_valid !== 1'b1 || sample_out !== 32'h700 + 32'(k)) begin
                tests_failed++;
                $display("FAIL rstmid_seg%0d: valid=%b out=%h, required valid=1 out=%h",
                         k, sample_valid, sample_out, 32'h700 + 32'(k));
            end
            tick();
        end
    endtask

`ifdef SEG_STREAM_SYMCNT_EN
    task automatic test_symcnt_wrap();
        sample_ready = 1'b0;
        force dut.r_symbol_count = 16'hFFFF;
        tick();
        release dut.r_symbol_count;
        tests_run++;
        if (symbol_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL symcnt_preload: got %h required ffff", symbol_count);
        end
        sample_ready = 1'b1;
        seg_in = mk_sym(32'h800); seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
        repeat (NUM_SEG) tick();
        tests_run++;
        if (symbol_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL symcnt_wrap: got %h required 0000", symbol_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef SEG_STREAM_SYMCNT_EN
        test_symcnt_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
